// File: rtl/rx_frame_ctrl.sv
// Serial receive framer: synchronizes the line, detects a start bit, samples
// DATA_BITS data bits LSB-first on bit-timer strobes and checks the stop bit.
module rx_frame_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 sample_strobe,
    input  logic                 data_read,
    output logic                 timer_clear,
    output logic                 timer_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START_CHK,
        DATA,
        STOP
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic                 sync1_reg;
    logic                 line_reg;
    logic                 line_prev_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic                 start_edge;
    logic                 good_load;
    logic                 bad_stop;

    assign start_edge = line_prev_reg & ~line_reg;
    assign good_load  = (state_reg == STOP) && sample_strobe && line_reg;
    assign bad_stop   = (state_reg == STOP) && sample_strobe && !line_reg;

    // New bit enters at the MSB so the first-received bit ends up at bit 0.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_next = line_reg;
        end else begin : g_shift_many
            assign shift_next = {line_reg, shift_reg[DATA_BITS-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg     <= IDLE;
            sync1_reg     <= 1'b1;
            line_reg      <= 1'b1;
            line_prev_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            sync1_reg     <= serial_in;
            line_reg      <= sync1_reg;
            line_prev_reg <= line_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_edge) state_next = CLEAR;
            end
            CLEAR: begin
                timer_clear = 1'b1;
                state_next  = START_CHK;
            end
            START_CHK: begin
                timer_enable = 1'b1;
                if (sample_strobe) state_next = line_reg ? IDLE : DATA;
            end
            DATA: begin
                timer_enable = 1'b1;
                if (sample_strobe && (bit_cnt_reg == LAST_BIT)) state_next = STOP;
            end
            STOP: begin
                timer_enable = 1'b1;
                if (sample_strobe) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            if ((state_reg == START_CHK) && sample_strobe && !line_reg) begin
                framing_error <= 1'b0;
                bit_cnt_reg   <= '0;
            end
            if ((state_reg == DATA) && sample_strobe) begin
                shift_reg   <= shift_next;
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
            // A load coinciding with a read wins over the read and never overruns.
            if (good_load) begin
                rx_data    <= shift_reg;
                data_ready <= 1'b1;
                if (data_read) begin
                    overrun_error <= 1'b0;
                end else if (data_ready) begin
                    overrun_error <= 1'b1;
                end
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            if (bad_stop) framing_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Self-checking bench for rx_frame_ctrl: drives framed bytes with explicit
// sample strobes and checks results through a scoreboard queue.
module tb_rx_frame_ctrl;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          serial_in = 1'b1;
    logic          sample_strobe = 1'b0;
    logic          data_read = 1'b0;
    logic          timer_clear;
    logic          timer_enable;
    logic [DB-1:0] rx_data;
    logic          data_ready;
    logic          framing_error;
    logic          overrun_error;

    int            tests_run = 0;
    int            tests_failed = 0;
    int            clear_total = 0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] saved_data;
    logic          saved_ready;
    logic          saved_fe;

    rx_frame_ctrl #(.DATA_BITS(DB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .sample_strobe (sample_strobe),
        .data_read     (data_read),
        .timer_clear   (timer_clear),
        .timer_enable  (timer_enable),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (timer_clear) clear_total++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    // Three edges let the new level pass through the two-flop synchronizer.
    task automatic settle_line(input logic b);
        serial_in = b;
        repeat (3) tick();
    endtask

    task automatic wait_enable();
        int n = 0;
        while (!timer_enable && n < 20) begin
            tick();
            n++;
        end
        check("start_chk_reached", {31'd0, timer_enable}, 32'd1);
    endtask

    task automatic send_start();
        serial_in = 1'b0;
        wait_enable();
        strobe();
    endtask

    task automatic send_bits(input logic [DB-1:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            settle_line(d[i]);
            strobe();
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic rd);
        int c0;
        logic [DB-1:0] e;
        c0 = clear_total;
        if (stop) exp_q.push_back(d);
        send_start();
        send_bits(d, DB);
        settle_line(stop);
        data_read = rd;
        strobe();
        data_read = 1'b0;
        check("clear_pulses", clear_total - c0, 32'd1);
        if (stop) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", {24'd0, rx_data}, {24'd0, e});
                check("data_ready", {31'd0, data_ready}, 32'd1);
            end
        end
        $display("[TB] frame 0x%02h stop=%0b read=%0b -> rx_data=0x%02h ready=%0b fe=%0b oe=%0b",
                 d, stop, rd, rx_data, data_ready, framing_error, overrun_error);
        settle_line(1'b1);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_ready", {31'd0, data_ready}, 32'd0);
        check("rst_fe", {31'd0, framing_error}, 32'd0);
        check("rst_oe", {31'd0, overrun_error}, 32'd0);
        check("rst_timer_clear", {31'd0, timer_clear}, 32'd0);
        check("rst_timer_enable", {31'd0, timer_enable}, 32'd0);
        n_rst = 1'b1;
        repeat (3) tick();

        // Framing error: word discarded, rx_data keeps its reset value.
        send_frame(8'h3C, 1'b0, 1'b0);
        check("fe_set", {31'd0, framing_error}, 32'd1);
        check("fe_ready", {31'd0, data_ready}, 32'd0);
        check("fe_rx_data", {24'd0, rx_data}, 32'd0);

        // Good byte; the valid start clears the framing error.
        send_frame(8'hA5, 1'b1, 1'b0);
        check("good_fe_cleared", {31'd0, framing_error}, 32'd0);
        check("good_oe", {31'd0, overrun_error}, 32'd0);
        check("good_idle_enable", {31'd0, timer_enable}, 32'd0);
        pulse_read();
        check("read_ready", {31'd0, data_ready}, 32'd0);

        // Overrun.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_oe", {31'd0, overrun_error}, 32'd1);
        pulse_read();
        check("ovr_read_ready", {31'd0, data_ready}, 32'd0);
        check("ovr_read_oe", {31'd0, overrun_error}, 32'd0);

        // Load/read collision.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b1);
        check("coll_oe", {31'd0, overrun_error}, 32'd0);
        pulse_read();
        check("coll_read_ready", {31'd0, data_ready}, 32'd0);

        // False start: two-cycle glitch, line high again by the START_CHK strobe.
        saved_data  = rx_data;
        saved_ready = data_ready;
        saved_fe    = framing_error;
        serial_in = 1'b0;
        repeat (2) tick();
        serial_in = 1'b1;
        wait_enable();
        repeat (2) tick();
        strobe();
        check("fs_enable_low", {31'd0, timer_enable}, 32'd0);
        check("fs_rx_data", {24'd0, rx_data}, {24'd0, saved_data});
        check("fs_ready", {31'd0, data_ready}, {31'd0, saved_ready});
        check("fs_fe", {31'd0, framing_error}, {31'd0, saved_fe});
        strobe();
        tick();
        strobe();
        check("idle_strobe_enable", {31'd0, timer_enable}, 32'd0);
        check("idle_strobe_ready", {31'd0, data_ready}, {31'd0, saved_ready});
        $display("[TB] false start -> enable=%0b rx_data=0x%02h", timer_enable, rx_data);

        // Reset mid-frame after four data bits of 0xFF.
        send_start();
        send_bits(8'hFF, 4);
        check("mid_enable", {31'd0, timer_enable}, 32'd1);
        n_rst = 1'b0;
        #1;
        check("mrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("mrst_ready", {31'd0, data_ready}, 32'd0);
        check("mrst_fe", {31'd0, framing_error}, 32'd0);
        check("mrst_oe", {31'd0, overrun_error}, 32'd0);
        check("mrst_timer_enable", {31'd0, timer_enable}, 32'd0);
        check("mrst_timer_clear", {31'd0, timer_clear}, 32'd0);
        $display("[TB] reset mid-frame -> rx_data=0x%02h enable=%0b", rx_data, timer_enable);
        tick();
        n_rst = 1'b1;
        settle_line(1'b1);
        send_frame(8'h5A, 1'b1, 1'b0);
        check("post_rst_fe", {31'd0, framing_error}, 32'd0);
        check("post_rst_oe", {31'd0, overrun_error}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Serial receive framer that consumes the one-cycle sample strobe from the bit-timer counter.
- It drives that counter's clear and count_enable inputs.
- It detects a start bit, samples DATA_BITS data bits LSB-first and checks the stop bit.
- Completed bytes are presented to the downstream consumer through a ready/read handshake, with framing and overrun error flags.

Parameters:
DATA_BITS, 8, number of data bits per frame (1..16)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
serial_in  input  1  raw asynchronous serial line, idle high
sample_strobe  input  1  one-cycle pulse from bit timer at each bit-sample point
data_read  input  1  consumer acknowledges rx_data (one-cycle pulse)
timer_clear  output  1  clears bit timer count
timer_enable  output  1  count_enable for bit timer
rx_data  output  DATA_BITS  last good received word
data_ready  output  1  rx_data holds unread data
framing_error  output  1  last frame had stop bit = 0
overrun_error  output  1  a word was overwritten before being read

Behaviour:
- Reset is asynchronous, active-low, on clk.
  - State goes to IDLE.
  - rx_data, data_ready, framing_error, overrun_error, timer_clear and timer_enable all go to 0.
  - Both synchronizer flops and the edge-detect flop go to 1 (idle line).
  - The internal shift register and bit counter go to 0.
- serial_in passes through a 2-flop synchronizer; "line" = synchronizer output, and all sampling uses line.
- Start edge = previous line 1 and current line 0.
- FSM states: IDLE, CLEAR, START_CHK, DATA, STOP.
  - IDLE: on start edge -> CLEAR. All other cycles, including any sample_strobe, stay in IDLE.
  - CLEAR: timer_clear=1 for exactly this one cycle; always -> START_CHK. sample_strobe is ignored.
  - START_CHK: timer_enable=1. On sample_strobe:
    - line==0: start valid; clear framing_error; bit_cnt=0 -> DATA.
    - line==1: false start -> IDLE; no flags change.
  - DATA: timer_enable=1. On sample_strobe, shift line into the MSB of the shift register (right shift, so LSB is received first) and increment bit_cnt. When the strobe that samples bit DATA_BITS-1 arrives -> STOP.
  - STOP: timer_enable=1. On sample_strobe -> IDLE, and:
    - line==1 (good frame): rx_data <= shift register and data_ready <= 1, both visible the cycle after the strobe. If data_ready was already 1 and data_read is 0 in the same cycle, overrun_error <= 1.
    - line==0: framing_error <= 1; rx_data and data_ready unchanged; the word is discarded.
- timer_enable=0 in IDLE and CLEAR; timer_clear=0 in every state except CLEAR.
- data_read=1:
  - data_ready <= 0 and overrun_error <= 0 on the next edge.
  - If it coincides with a good-frame load, the load wins: data_ready stays 1, rx_data gets the new word, and no overrun is flagged.
- framing_error holds until the next valid start bit (START_CHK with line==0). overrun_error holds until data_read.
- A start edge during CLEAR, START_CHK, DATA or STOP is ignored; only IDLE arms the receiver.
- Back-to-back frames: after STOP returns to IDLE, a falling line on the following cycles is accepted as the next start.
- Latency: rx_data and data_ready update on the clk edge that samples the stop-bit strobe.
- Asserting n_rst mid-frame aborts immediately: all outputs return to reset values and the partial word is lost.

Test Plan:
- Good byte: idle line, send start, 0xA5 LSB-first, stop=1, one sample_strobe per bit -> rx_data=0xA5, data_ready=1 the cycle after the stop strobe; timer_clear pulsed exactly once; errors 0.
- Framing error: send 0x3C with stop=0 -> framing_error=1, data_ready stays 0, rx_data keeps its previous value (0x00 after reset); next valid start clears framing_error.
- Overrun: receive 0x11, do not assert data_read, receive 0x22 -> rx_data=0x22, data_ready=1, overrun_error=1. Then pulse data_read -> data_ready=0, overrun_error=0 next cycle.
- Load/read collision: data_read pulsed on the same cycle as the stop strobe of the second byte 0x7E -> rx_data=0x7E, data_ready=1, overrun_error=0.
- False start: 2-cycle low glitch, line high at the START_CHK strobe -> back to IDLE; timer_enable drops to 0; no flag or data change; strobes in IDLE ignored.
- Reset mid-frame: assert n_rst after 4 data-bit strobes of 0xFF -> all outputs 0, state IDLE. A subsequent full frame of 0x5A -> rx_data=0x5A with no residue from the aborted frame.
